fs_zcu106: RTL and testbench

// - FPGA top-level console block: one-clock UART (8N1) serial console with status LEDs.
// - After reset and enable, it transmits a fixed banner once. It then echoes every valid byte received on ser_rx.
// - Sits at the board pins (ser_rx/ser_tx/leds). A host-side testbench UART decodes ser_tx and prints the characters.

---
 rtl/fs_console_pkg.sv | 28 ++
 rtl/fs_uart_tx.sv | 60 ++++++
 rtl/fs_zcu106.sv | 152 +++++++++++++++
 tb/tb_fs_zcu106.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_console_pkg.sv
// Shared constants, state types and banner table for the fs_zcu106 serial console.
package fs_console_pkg;

  localparam int CLK_DIV_DEFAULT = 868;
  localparam int BANNER_LEN      = 11;

  typedef enum logic [1:0] {BOOT, BANNER, ECHO} top_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // "FS ZCU106\r\n"
  function automatic logic [7:0] banner_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    banner_byte = 8'h46;
      4'd1:    banner_byte = 8'h53;
      4'd2:    banner_byte = 8'h20;
      4'd3:    banner_byte = 8'h5A;
      4'd4:    banner_byte = 8'h43;
      4'd5:    banner_byte = 8'h55;
      4'd6:    banner_byte = 8'h31;
      4'd7:    banner_byte = 8'h30;
      4'd8:    banner_byte = 8'h36;
      4'd9:    banner_byte = 8'h0D;
      4'd10:   banner_byte = 8'h0A;
      default: banner_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/fs_uart_tx.sv
// 8N1 UART transmitter; busy drops in the last stop-bit cycle so a queued byte
// can load with no idle gap between frames.
module fs_uart_tx
  import fs_console_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (baud_cnt == CW'(CLK_DIV - 1));
  assign frame_end = active && bit_end && (bit_idx == 4'd9);
  assign busy      = active && !frame_end;

  // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
    end else if (ld && !busy) begin
      tx       <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= {1'b1, data};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fs_zcu106.sv
// Board-level serial console: sends the banner once, then echoes received bytes.
// Define FS_RX_ECHO_EN to build the receive/echo path; otherwise ser_rx is ignored.
module fs_zcu106
  import fs_console_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [1:0] leds
);

  top_state_t  state;
  logic [3:0]  banner_idx;
  logic        led_done;
  logic        led_rx;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic        tx_busy;
  logic        banner_ld;
  logic        echo_ld;
  logic        tx_ld;
  logic [7:0]  tx_data;

  assign banner_ld = enb && (state == BANNER) && (banner_idx < 4'(BANNER_LEN)) && !tx_busy;
  assign echo_ld   = enb && (state == ECHO) && hold_full && !tx_busy;
  assign tx_ld     = banner_ld || echo_ld;
  assign tx_data   = banner_ld ? banner_byte(banner_idx) : hold_data;
  assign leds      = {led_rx, led_done};

  fs_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk  (clk),
    .rst  (rst),
    .ld   (tx_ld),
    .data (tx_data),
    .tx   (ser_tx),
    .busy (tx_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      banner_idx <= '0;
      led_done   <= 1'b0;
    end else if (enb) begin
      case (state)
        BOOT:   state <= BANNER;
        BANNER: begin
          if (banner_ld) begin
            banner_idx <= banner_idx + 1'b1;
          end else if (banner_idx == 4'(BANNER_LEN) && !tx_busy) begin
            state    <= ECHO;
            led_done <= 1'b1;
          end
        end
        default: state <= ECHO;
      endcase
    end
  end

`ifdef FS_RX_ECHO_EN
  localparam int CW = $clog2(CLK_DIV);

  rx_state_t     rx_state;
  logic [2:0]    rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;

  // rx_sync[1] is the synchronized line, rx_sync[2] its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[1:0], ser_rx};
      rx_valid <= 1'b0;
      if (!enb) begin
        rx_state <= RX_IDLE;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_sync[2] && !rx_sync[1]) begin
              rx_state <= RX_START;
              rx_cnt   <= '0;
            end
          end
          RX_START: begin
            if (rx_cnt == CW'(CLK_DIV / 2 - 1)) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_cnt == CW'(CLK_DIV - 1)) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_sync[1], rx_shift[7:1]};
              rx_bit   <= rx_bit + 1'b1;
              if (rx_bit == 4'd7) rx_state <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: begin
            if (rx_cnt == CW'(CLK_DIV - 1)) begin
              rx_cnt   <= '0;
              rx_state <= RX_IDLE;
              rx_valid <= rx_sync[1];
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // A byte arriving while the register is full is dropped unless it is being emptied now.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      led_rx    <= 1'b0;
    end else begin
      if (echo_ld) hold_full <= 1'b0;
      if (rx_valid && (!hold_full || echo_ld)) begin
        hold_full <= 1'b1;
        hold_data <= rx_shift;
        led_rx    <= ~led_rx;
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ser_rx;
  assign hold_full = 1'b0;
  assign hold_data = '0;
  assign led_rx    = 1'b0;
`endif

endmodule

// File: tb/tb_fs_zcu106.sv
// Self-checking bench for fs_zcu106: decodes ser_tx frame by frame and compares
// against the banner text and the bytes driven on ser_rx.
module tb_fs_zcu106;

  localparam int CLK_DIV = 32;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       ser_rx;
  logic       ser_tx;
  logic [1:0] leds;

  int vectors     = 0;
  int miscompares = 0;
  logic exp_led1  = 1'b0;

  string banner = "FS ZCU106\r\n";

  fs_zcu106 #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .ser_rx (ser_rx),
    .ser_tx (ser_tx),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  // Frame decoder: every cycle of each bit must match the bit's first cycle,
  // data is taken at bit centre, start must be 0 and stop 1.
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc = 0;
  int         mon_err = 0;
  bit         m_active = 1'b0;
  bit         m_bad;
  int         m_pos, m_b, m_off, m_start;
  logic       m_ref;
  logic [9:0] m_bits;

  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && ser_tx === 1'b0) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_bad    = 1'b0;
        m_start  = cyc;
      end
      if (m_active) begin
        m_b   = m_pos / CLK_DIV;
        m_off = m_pos % CLK_DIV;
        if (m_off == 0) m_ref = ser_tx;
        else if (ser_tx !== m_ref) m_bad = 1'b1;
        if (m_off == CLK_DIV / 2) m_bits[m_b] = ser_tx;
        if (m_pos == FRAME - 1) begin
          if (m_bad || m_bits[0] !== 1'b0 || m_bits[9] !== 1'b1) mon_err++;
          else begin
            got_q.push_back(m_bits[8:1]);
            got_t.push_back(m_start);
          end
          m_active = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int banner_errs();
    int e = 0;
    logic [7:0] c;
    if (got_q.size() < 11) return 11;
    for (int i = 0; i < 11; i++) begin
      c = banner[i];
      if (got_q[i] !== c) e++;
    end
    return e;
  endfunction

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; enb = 1'b0; ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete(); got_t.delete();
    exp_led1 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b0; ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL reset_ser_tx: got %b want 1", ser_tx); end
    vectors++; if (leds !== 2'b00) begin miscompares++; $display("FAIL reset_leds: got %b want 00", leds); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL boot_ser_tx: got %b want 1", ser_tx); end
  endtask

  task automatic test_banner();
    bit ok;
    int bad = 0;
    logic [7:0] c;
    #10 enb = 1'b1;
    wait_bytes(10, 12 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL banner_timeout10: got %0d bytes want 10", got_q.size()); end
    vectors++; if (leds[0] !== 1'b0) begin miscompares++; $display("FAIL banner_early_done: got %b want 0", leds[0]); end
    wait_bytes(11, 2 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL banner_timeout11: got %0d bytes want 11", got_q.size()); end
    repeat (2) @(negedge clk);
    vectors++; if (leds !== 2'b01) begin miscompares++; $display("FAIL banner_leds: got %b want 01", leds); end
    for (int i = 0; i < 11; i++) begin
      c = banner[i];
      vectors++;
      if (got_q.size() <= i || got_q[i] !== c) begin
        miscompares++;
        $display("FAIL banner_byte%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, c);
      end
    end
    for (int i = 1; i < got_t.size(); i++) if (got_t[i] - got_t[i-1] != FRAME) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL banner_frame_spacing: got %0d bad gaps want 0", bad); end
    vectors++; if (mon_err != 0) begin miscompares++; $display("FAIL banner_frame_format: got %0d bad frames want 0", mon_err); end
  endtask

`ifdef FS_RX_ECHO_EN
  task automatic test_echo();
    bit ok;
    logic [7:0] b;
    got_q.delete(); got_t.delete();
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h41 : 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      exp_led1 = ~exp_led1;
      wait_bytes(k + 1, 3 * FRAME, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL echo_timeout%0d: got %0d bytes want %0d", k, got_q.size(), k + 1); end
      vectors++; if (got_q.size() <= k || got_q[k] !== b) begin miscompares++; $display("FAIL echo_byte%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, b); end
      vectors++; if (leds[1] !== exp_led1) begin miscompares++; $display("FAIL echo_led%0d: got %b want %b", k, leds[1], exp_led1); end
      repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
    end
  endtask

  task automatic test_framing();
    int n = got_q.size();
    send_rx(8'h42, 1'b0);
    repeat (3 * FRAME) @(negedge clk);
    vectors++; if (got_q.size() != n) begin miscompares++; $display("FAIL framing_no_echo: got %0d bytes want %0d", got_q.size(), n); end
    vectors++; if (leds[1] !== exp_led1) begin miscompares++; $display("FAIL framing_led: got %b want %b", leds[1], exp_led1); end
  endtask

  task automatic test_glitch();
    int n = got_q.size();
    ser_rx = 1'b0;
    repeat ($urandom_range(1, CLK_DIV / 2 - 3)) @(negedge clk);
    ser_rx = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    vectors++; if (got_q.size() != n) begin miscompares++; $display("FAIL glitch_no_echo: got %0d bytes want %0d", got_q.size(), n); end
    vectors++; if (leds[1] !== exp_led1) begin miscompares++; $display("FAIL glitch_led: got %b want %b", leds[1], exp_led1); end
  endtask

  // The banner keeps TX busy, so only the first of three back-to-back bytes is kept.
  task automatic test_overrun();
    bit ok;
    apply_reset();
    enb = 1'b1;
    wait_bytes(1, 3 * FRAME, ok);
    send_rx(8'h31, 1'b1);
    send_rx(8'h32, 1'b1);
    send_rx(8'h33, 1'b1);
    wait_bytes(12, 14 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL overrun_timeout: got %0d bytes want 12", got_q.size()); end
    repeat (3 * FRAME) @(negedge clk);
    vectors++; if (got_q.size() != 12) begin miscompares++; $display("FAIL overrun_count: got %0d bytes want 12", got_q.size()); end
    vectors++; if (banner_errs() != 0) begin miscompares++; $display("FAIL overrun_banner: got %0d bad bytes want 0", banner_errs()); end
    vectors++; if (got_q.size() < 12 || got_q[11] !== 8'h31) begin miscompares++; $display("FAIL overrun_echo: got %h want 31", (got_q.size() > 11) ? got_q[11] : 8'hxx); end
    vectors++; if (leds !== 2'b11) begin miscompares++; $display("FAIL overrun_leds: got %b want 11", leds); end
  endtask
`else
  task automatic test_no_echo();
    int n = got_q.size();
    send_rx(8'h41, 1'b1);
    repeat (3 * FRAME) @(negedge clk);
    vectors++; if (got_q.size() != n) begin miscompares++; $display("FAIL no_echo_count: got %0d bytes want %0d", got_q.size(), n); end
    vectors++; if (leds !== 2'b01) begin miscompares++; $display("FAIL no_echo_leds: got %b want 01", leds); end
  endtask
`endif

  task automatic test_pause();
    bit ok;
    apply_reset();
    enb = 1'b1;
    wait_bytes(2, 4 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pause_timeout2: got %0d bytes want 2", got_q.size()); end
    repeat ($urandom_range(CLK_DIV, 8 * CLK_DIV)) @(negedge clk);
    enb = 1'b0;
    repeat (20000) @(negedge clk);
    vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL pause_count: got %0d bytes want 3", got_q.size()); end
    vectors++; if (got_q.size() < 3 || got_q[2] !== 8'h20) begin miscompares++; $display("FAIL pause_byte3: got %h want 20", (got_q.size() > 2) ? got_q[2] : 8'hxx); end
    vectors++; if (leds !== 2'b00) begin miscompares++; $display("FAIL pause_leds: got %b want 00", leds); end
    enb = 1'b1;
    wait_bytes(11, 10 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL resume_timeout: got %0d bytes want 11", got_q.size()); end
    repeat (2 * FRAME) @(negedge clk);
    vectors++; if (got_q.size() != 11) begin miscompares++; $display("FAIL resume_count: got %0d bytes want 11", got_q.size()); end
    vectors++; if (got_q.size() < 4 || got_q[3] !== 8'h5A) begin miscompares++; $display("FAIL resume_byte4: got %h want 5a", (got_q.size() > 3) ? got_q[3] : 8'hxx); end
    vectors++; if (banner_errs() != 0) begin miscompares++; $display("FAIL resume_banner: got %0d bad bytes want 0", banner_errs()); end
    vectors++; if (leds[0] !== 1'b1) begin miscompares++; $display("FAIL resume_done: got %b want 1", leds[0]); end
    vectors++; if (mon_err != 0) begin miscompares++; $display("FAIL resume_frame_format: got %0d bad frames want 0", mon_err); end
  endtask

  // Reset lands inside the start bit of the second banner frame.
  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    enb = 1'b1;
    wait_bytes(1, 3 * FRAME, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout1: got %0d bytes want 1", got_q.size()); end
    repeat ($urandom_range(1, CLK_DIV - 3)) @(negedge clk);
    vectors++; if (ser_tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_start_bit: got %b want 0", ser_tx); end
    rst = 1'b1;
    got_q.delete(); got_t.delete();
    @(negedge clk);
    vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_ser_tx: got %b want 1", ser_tx); end
    vectors++; if (leds !== 2'b00) begin miscompares++; $display("FAIL rstmid_leds: got %b want 00", leds); end
    rst = 1'b0;
    wait_bytes(1, 3 * FRAME, ok);
    vectors++; if (got_q.size() < 1 || got_q[0] !== 8'h46) begin miscompares++; $display("FAIL rstmid_first: got %h want 46", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    wait_bytes(11, 12 * FRAME, ok);
    repeat (2) @(negedge clk);
    vectors++; if (banner_errs() != 0) begin miscompares++; $display("FAIL rstmid_banner: got %0d bad bytes want 0", banner_errs()); end
    vectors++; if (leds[0] !== 1'b1) begin miscompares++; $display("FAIL rstmid_done: got %b want 1", leds[0]); end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; ser_rx = 1'b1;
    test_reset();
    test_banner();
`ifdef FS_RX_ECHO_EN
    test_echo();
    test_framing();
    test_glitch();
    test_overrun();
`else
    test_no_echo();
`endif
    test_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
